fifo_rd_arbiter: RTL and testbench
==================================

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: FIFO read data width.
REQ-002 SHALL have parameter N_REQ, default 4: number of consumers sharing the FIFO read port.
REQ-003 SHALL have parameter BURST_MAX, default 8: maximum words per grant.
REQ-004 SHALL have parameter HOLD_MAX, default 16: maximum consecutive empty cycles tolerated while granted.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; ports listed below.
REQ-006 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-007 rrst  input  1  asynchronous active-high reset.
REQ-008 fifo_rempty_i  input  1  FIFO read-side empty flag.
REQ-009 fifo_rdata_i  input  DATA_W  FIFO word at the current read address; valid whenever fifo_rempty_i=0.
REQ-010 fifo_rincr_o  output  1  pop strobe to the FIFO read pointer controller.
REQ-011 req_i  input  N_REQ  per-consumer request, level.
REQ-012 ready_i  input  N_REQ  per-consumer accept.
REQ-013 gnt_o  output  N_REQ  registered one-hot grant.
REQ-014 rvalid_o  output  N_REQ  per-consumer data valid.
REQ-015 rdata_o  output  DATA_W  broadcast read data, combinational copy of fifo_rdata_i.
REQ-016 busy_o  output  1  high while in the XFER state.

Function
REQ-017 SHALL implement two states, IDLE and XFER.
REQ-018 IDLE: if any req_i bit is high, the block SHALL select a winner round-robin, starting at (last_gnt+1) mod N_REQ, then register gnt_o and enter XFER on the next edge; otherwise it SHALL remain in IDLE with gnt_o=0.
REQ-019 Grant latency SHALL be exactly one cycle from req_i sampled high in IDLE to gnt_o high.
REQ-020 In XFER, rvalid_o[g] SHALL equal gnt_o[g] & ~fifo_rempty_i; all other rvalid_o bits SHALL be 0.
REQ-021 fifo_rincr_o SHALL equal |(rvalid_o & ready_i); a transfer occurs in each cycle where it is 1.
REQ-022 A burst counter (width clog2(BURST_MAX+1)) SHALL clear on entry to XFER and increment on each transfer.
REQ-023 XFER SHALL return to IDLE (gnt_o cleared, last_gnt updated) at the edge where any of the following holds:
- the transfer in that cycle makes the count equal BURST_MAX;
- req_i[g]=0, with any transfer in the same cycle still completed;
- the empty-hold counter reaches HOLD_MAX.
REQ-024 The empty-hold counter SHALL increment on each XFER cycle with fifo_rempty_i=1 and clear on any cycle with fifo_rempty_i=0 or on entry to XFER.
REQ-025 On the IDLE cycle after a release, the block SHALL arbitrate again, so there is a one-cycle gap between grants; back-to-back bursts to the same consumer are allowed only if no other req_i bit is high.
REQ-026 gnt_o SHALL never have more than one bit set; fifo_rincr_o SHALL never assert while fifo_rempty_i=1 or in IDLE.

Reset
REQ-027 While rrst=1, the block SHALL hold: state=IDLE, gnt_o=0, rvalid_o=0, fifo_rincr_o=0, busy_o=0, counters=0, last_gnt=N_REQ-1 (consumer 0 wins first).
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously), with no pop on that cycle.

Structure
REQ-029 State encodings (IDLE=0, XFER=1) and the parameter defaults SHALL live in shared package fifo_pkg.
REQ-030 Winner selection SHALL be a sub-module rr_pick: N_REQ-wide request vector plus last_gnt index in, one-hot winner and index out, purely combinational.

Verification
REQ-031 Reset release, req_i=4'b0101, FIFO holds 20 words, all ready -> gnt_o=0001 one cycle later; 8 pops; IDLE gap; gnt_o=0100; 8 pops.
REQ-032 req_i=4'b1111 held, FIFO never empty -> grant order 0,1,2,3,0 with 8 pops each.
REQ-033 Granted consumer 1 drops req_i after 3 transfers -> release at that edge, count=3, next grant goes to consumer 2.
REQ-034 Granted with FIFO empty for 16 cycles -> rvalid_o=0, no pops, release after the 16th empty cycle.
REQ-035 ready_i[0] toggles 1,0,1,0 during a burst -> pops only on cycles with ready=1; rdata_o order matches FIFO order.
REQ-036 rrst pulsed at the 4th beat of a burst -> outputs zero immediately; after release, consumer 0 is granted first.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-port arbiter: FSM encoding and parameter defaults.
package fifo_pkg;
   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   localparam int DATA_W_DEF    = 8;
   localparam int N_REQ_DEF     = 4;
   localparam int BURST_MAX_DEF = 8;
   localparam int HOLD_MAX_DEF  = 16;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select; the search starts one past the last grant.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_last,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IW-1:0]    o_idx
);
   logic w_found;
   int   w_c;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_c     = 0;
      // k runs 1..N_REQ so the last winner is considered last.
      for (int k = 1; k <= N_REQ; k++) begin
         w_c = (int'(i_last) + k) % N_REQ;
         if (!w_found && i_req[w_c]) begin
            w_found    = 1'b1;
            o_gnt[w_c] = 1'b1;
            o_idx      = IW'(w_c);
         end
      end
   end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares one FIFO read port among N_REQ consumers with round-robin, burst-limited grants.
module fifo_rd_arbiter
   import fifo_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int N_REQ     = N_REQ_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF,
   parameter int HOLD_MAX  = HOLD_MAX_DEF
) (
   input  logic              rclk,
   input  logic              rrst,
   input  logic              fifo_rempty_i,
   input  logic [DATA_W-1:0] fifo_rdata_i,
   output logic              fifo_rincr_o,
   input  logic [N_REQ-1:0]  req_i,
   input  logic [N_REQ-1:0]  ready_i,
   output logic [N_REQ-1:0]  gnt_o,
   output logic [N_REQ-1:0]  rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              busy_o
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam int HW = $clog2(HOLD_MAX + 1);

   arb_state_e        r_state, w_state_nxt;
   logic [N_REQ-1:0]  r_gnt;
   logic [IW-1:0]     r_gidx;
   logic [IW-1:0]     r_last;
   logic [BW-1:0]     r_burst, w_burst_nxt;
   logic [HW-1:0]     r_hold, w_hold_nxt;
   logic [N_REQ-1:0]  w_pick, w_rvalid;
   logic [IW-1:0]     w_pidx;
   logic              w_pop, w_release;

   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .i_req  (req_i),
      .i_last (r_last),
      .o_gnt  (w_pick),
      .o_idx  (w_pidx)
   );

   always_comb begin
      w_rvalid    = (r_state == XFER) ? (r_gnt & {N_REQ{~fifo_rempty_i}}) : '0;
      w_pop       = |(w_rvalid & ready_i);
      w_burst_nxt = r_burst + BW'(w_pop);
      w_hold_nxt  = fifo_rempty_i ? r_hold + HW'(1) : '0;
      // A dropped request still lets this cycle's transfer complete.
      w_release   = (w_pop && (w_burst_nxt == BW'(BURST_MAX))) ||
                    !(|(req_i & r_gnt)) ||
                    (w_hold_nxt == HW'(HOLD_MAX));
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (|req_i) w_state_nxt = XFER;
         XFER:    if (w_release) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_gidx  <= '0;
         r_last  <= IW'(N_REQ - 1);
         r_burst <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE) begin
            if (|req_i) begin
               r_gnt   <= w_pick;
               r_gidx  <= w_pidx;
               r_burst <= '0;
               r_hold  <= '0;
            end
         end else begin
            r_burst <= w_burst_nxt;
            r_hold  <= w_hold_nxt;
            if (w_release) begin
               r_gnt  <= '0;
               r_last <= r_gidx;
            end
         end
      end
   end

   assign gnt_o        = r_gnt;
   assign rvalid_o     = w_rvalid;
   assign fifo_rincr_o = w_pop;
   assign rdata_o      = fifo_rdata_i;
   assign busy_o       = (r_state == XFER);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a small array-backed FIFO model.
module tb_fifo_rd_arbiter;
   logic       rclk = 1'b0;
   logic       rrst;
   logic       fifo_rempty_i, fifo_rincr_o, busy_o;
   logic [7:0] fifo_rdata_i, rdata_o;
   logic [3:0] req_i, ready_i, gnt_o, rvalid_o;

   logic [7:0] mem [256];
   logic [7:0] rptr = 8'd0;
   logic [7:0] wptr;
   logic       fifo_clr, force_empty;
   int         n_chk = 0;
   int         n_fail = 0;
   int         exp_idx;

   always #5 rclk = ~rclk;

   assign fifo_rempty_i = (rptr == wptr) || force_empty;
   assign fifo_rdata_i  = mem[rptr];

   always @(posedge rclk) begin
      if (fifo_clr) rptr <= 8'd0;
      else if (fifo_rincr_o) rptr <= rptr + 8'd1;
   end

   fifo_rd_arbiter dut (
      .rclk(rclk), .rrst(rrst), .fifo_rempty_i(fifo_rempty_i), .fifo_rdata_i(fifo_rdata_i),
      .fifo_rincr_o(fifo_rincr_o), .req_i(req_i), .ready_i(ready_i), .gnt_o(gnt_o),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .busy_o(busy_o)
   );

   function automatic logic [7:0] word(input int i);
      return 8'(i * 3 + 1);
   endfunction

   task automatic do_reset(input logic [7:0] level);
      rrst = 1'b1; fifo_clr = 1'b1; req_i = '0; ready_i = '0; force_empty = 1'b0; wptr = level;
      repeat (2) @(negedge rclk);
      fifo_clr = 1'b0; exp_idx = 0; rrst = 1'b0;
   endtask

   // Observes one grant to completion and reports what happened; no judgement here.
   task automatic watch(output logic [3:0] g, output int pops, output int cyc, output int waitc,
                        output int bad, output logic rv_seen);
      pops = 0; cyc = 0; waitc = 0; bad = 0; rv_seen = 1'b0;
      while (gnt_o == 4'b0 && waitc < 40) begin
         @(negedge rclk); #1; waitc++;
      end
      g = gnt_o;
      while (gnt_o != 4'b0 && cyc < 60) begin
         rv_seen = rv_seen | (|rvalid_o);
         if (!$onehot(gnt_o)) bad++;
         if (fifo_rincr_o) begin
            if (fifo_rempty_i || rdata_o !== word(exp_idx)) bad++;
            exp_idx++; pops++;
         end
         cyc++;
         @(negedge rclk); #1;
      end
   endtask

   task automatic test_reset;
      rrst = 1'b1; fifo_clr = 1'b1; req_i = 4'hF; ready_i = 4'hF; force_empty = 1'b0; wptr = 8'd10;
      repeat (2) @(negedge rclk); #1;
      n_chk++; if (gnt_o !== 4'b0) begin n_fail++; $display("FAIL rst_gnt got %b want 0000", gnt_o); end
      n_chk++; if (rvalid_o !== 4'b0) begin n_fail++; $display("FAIL rst_rvalid got %b want 0000", rvalid_o); end
      n_chk++; if (fifo_rincr_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_incr_busy got %b%b want 00", fifo_rincr_o, busy_o); end
   endtask

   task automatic test_two_req;
      logic [3:0] g; int p, c, w, b; logic rv;
      do_reset(8'd20);
      ready_i = 4'hF; req_i = 4'b0101; #1;
      n_chk++; if (gnt_o !== 4'b0) begin n_fail++; $display("FAIL t1_latency got %b want 0000", gnt_o); end
      @(negedge rclk); #1;
      n_chk++; if (gnt_o !== 4'b0001 || busy_o !== 1'b1) begin n_fail++; $display("FAIL t1_gnt0 got %b busy %b want 0001 1", gnt_o, busy_o); end
      watch(g, p, c, w, b, rv);
      n_chk++; if (p != 8 || c != 8 || b != 0) begin n_fail++; $display("FAIL t1_burst0 got pops %0d cyc %0d bad %0d want 8 8 0", p, c, b); end
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL t1_gap_busy got %b want 0", busy_o); end
      watch(g, p, c, w, b, rv);
      n_chk++; if (g !== 4'b0100 || w != 1) begin n_fail++; $display("FAIL t1_gnt2 got %b gap %0d want 0100 1", g, w); end
      n_chk++; if (p != 8 || b != 0) begin n_fail++; $display("FAIL t1_burst2 got pops %0d bad %0d want 8 0", p, b); end
      req_i = '0;
   endtask

   task automatic test_round_robin;
      logic [3:0] g; int p, c, w, b; logic rv;
      logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset(8'd200);
      ready_i = 4'hF; req_i = 4'hF;
      for (int i = 0; i < 5; i++) begin
         watch(g, p, c, w, b, rv);
         n_chk++; if (g !== order[i] || p != 8 || b != 0) begin n_fail++; $display("FAIL rr_%0d got %b pops %0d bad %0d want %b 8 0", i, g, p, b, order[i]); end
      end
      req_i = '0;
   endtask

   task automatic test_req_drop;
      do_reset(8'd50);
      ready_i = 4'hF; req_i = 4'b0010;
      @(negedge rclk); #1;
      n_chk++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL drop_gnt1 got %b want 0010", gnt_o); end
      for (int k = 1; k <= 3; k++) begin
         if (k == 1) req_i = 4'b0111;
         if (k == 3) req_i = 4'b0101;
         #1;
         n_chk++; if (fifo_rincr_o !== 1'b1) begin n_fail++; $display("FAIL drop_pop%0d got %b want 1", k, fifo_rincr_o); end
         @(negedge rclk); #1;
      end
      n_chk++; if (gnt_o !== 4'b0 || busy_o !== 1'b0 || rptr !== 8'd3) begin n_fail++; $display("FAIL drop_release got gnt %b busy %b pops %0d want 0000 0 3", gnt_o, busy_o, rptr); end
      @(negedge rclk); #1;
      n_chk++; if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL drop_next got %b want 0100", gnt_o); end
      req_i = '0;
   endtask

   task automatic test_empty_hold;
      logic [3:0] g; int p, c, w, b; logic rv;
      do_reset(8'd0);
      ready_i = 4'hF; req_i = 4'b0001;
      watch(g, p, c, w, b, rv);
      n_chk++; if (g !== 4'b0001 || c != 16) begin n_fail++; $display("FAIL hold_len got %b cyc %0d want 0001 16", g, c); end
      n_chk++; if (p != 0 || rv !== 1'b0 || b != 0) begin n_fail++; $display("FAIL hold_quiet got pops %0d rvalid %b bad %0d want 0 0 0", p, rv, b); end
      req_i = '0;
   endtask

   task automatic test_ready_toggle;
      logic [3:0] pat = 4'b0101;
      logic [7:0] exp_d [4] = '{8'h01, 8'h04, 8'h04, 8'h07};
      do_reset(8'd20);
      ready_i = 4'b0001; req_i = 4'b0001;
      @(negedge rclk);
      for (int k = 0; k < 4; k++) begin
         ready_i = {3'b0, pat[k]}; #1;
         n_chk++; if (fifo_rincr_o !== pat[k] || rvalid_o !== 4'b0001 || rdata_o !== exp_d[k]) begin n_fail++; $display("FAIL rdy_%0d got incr %b rv %b data %h want %b 0001 %h", k, fifo_rincr_o, rvalid_o, rdata_o, pat[k], exp_d[k]); end
         @(negedge rclk);
      end
      #1;
      n_chk++; if (rptr !== 8'd2) begin n_fail++; $display("FAIL rdy_pops got %0d want 2", rptr); end
      req_i = '0;
   endtask

   task automatic test_reset_midburst;
      do_reset(8'd50);
      ready_i = 4'hF; req_i = 4'b0001;
      repeat (4) @(negedge rclk);
      #1; rrst = 1'b1; #1;
      n_chk++; if (gnt_o !== 4'b0 || rvalid_o !== 4'b0 || fifo_rincr_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_abort got gnt %b rv %b incr %b busy %b want 0000 0000 0 0", gnt_o, rvalid_o, fifo_rincr_o, busy_o); end
      req_i = 4'hF;
      @(negedge rclk); #1;
      n_chk++; if (rptr !== 8'd3) begin n_fail++; $display("FAIL mid_pops got %0d want 3", rptr); end
      rrst = 1'b0; #1;
      n_chk++; if (gnt_o !== 4'b0) begin n_fail++; $display("FAIL mid_idle got %b want 0000", gnt_o); end
      @(negedge rclk); #1;
      n_chk++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL mid_first got %b want 0001", gnt_o); end
      req_i = '0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = word(i);
      test_reset;
      test_two_req;
      test_round_robin;
      test_req_drop;
      test_empty_hold;
      test_ready_toggle;
      test_reset_midburst;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
